// File: rtl/quad_step_decoder.sv
// quad_step_decoder
// Incremental-encoder front end: synchronizes and filters the A/B phase
// lines, decodes Gray-code moves into direction plus a one-cycle step
// pulse, and keeps a loadable, wrapping position count.
//
// Handshake: step is a one-cycle valid strobe with no ready. Whenever step
// is high, up_down and counter_out hold that step's direction and the
// updated position (unless a same-cycle load overrode the position).
module quad_step_decoder #(
  parameter int CNT_WIDTH  = 3,
  parameter int FILTER_LEN = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enc_a,
  input  logic                 enc_b,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] counter_in,
  input  logic                 clr_err,
  output logic                 step,
  output logic                 up_down,
  output logic [CNT_WIDTH-1:0] counter_out,
  output logic                 err,
  output logic                 state_dbg
);

  typedef enum logic {
    UNPRIMED = 1'b0,
    TRACK    = 1'b1
  } state_t;

  localparam logic [3:0]           FLEN    = FILTER_LEN[3:0];
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t     state;
  logic [1:0] sync1;
  logic [1:0] sync2;
  logic [1:0] last_pair;
  logic [1:0] filt;
  logic [3:0] stab_cnt;
  logic [3:0] stab_next;
  logic [1:0] pos_old;
  logic [1:0] pos_new;
  logic [1:0] pos_diff;
  logic       accept;
  logic       is_up;
  logic       is_down;
  logic       is_illegal;
  logic       bad_move;

  // Position of a pair along the up sequence 00 -> 10 -> 11 -> 01.
  function automatic logic [1:0] gray_pos(input logic [1:0] pair);
    case (pair)
      2'b00:   gray_pos = 2'd0;
      2'b10:   gray_pos = 2'd1;
      2'b11:   gray_pos = 2'd2;
      default: gray_pos = 2'd3;
    endcase
  endfunction

  // Two-flop synchronizer on the raw phase lines.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 2'b00;
      sync2 <= 2'b00;
    end else begin
      sync1 <= {enc_a, enc_b};
      sync2 <= sync1;
    end
  end

  // Stability count, acceptance and move classification for this edge.
  always_comb begin
    if (sync2 == last_pair) begin
      stab_next = (stab_cnt == 4'hF) ? 4'hF : stab_cnt + 4'd1;
    end else begin
      stab_next = 4'd1;
    end
    accept     = (stab_next >= FLEN) && (sync2 != filt);
    pos_old    = gray_pos(filt);
    pos_new    = gray_pos(sync2);
    pos_diff   = pos_new - pos_old;
    is_up      = (pos_diff == 2'd1);
    is_down    = (pos_diff == 2'd3);
    is_illegal = (pos_diff == 2'd2);
    bad_move   = accept && (state == TRACK) && is_illegal;
  end

  // Filter state, priming FSM, step/direction, position count and err.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= UNPRIMED;
      filt        <= 2'b00;
      last_pair   <= 2'b00;
      stab_cnt    <= 4'd0;
      step        <= 1'b0;
      up_down     <= 1'b0;
      counter_out <= '0;
      err         <= 1'b0;
    end else begin
      last_pair <= sync2;
      stab_cnt  <= stab_next;
      step      <= 1'b0;
      if (accept) begin
        filt <= sync2;
        case (state)
          UNPRIMED: state <= TRACK;
          TRACK: begin
            if (is_up) begin
              step        <= 1'b1;
              up_down     <= 1'b1;
              counter_out <= counter_out + CNT_ONE;
            end else if (is_down) begin
              step        <= 1'b1;
              up_down     <= 1'b0;
              counter_out <= counter_out - CNT_ONE;
            end
          end
          default: state <= UNPRIMED;
        endcase
      end
      // A load overrides any same-edge count change.
      if (load) begin
        counter_out <= counter_in;
      end
      // An illegal move on the same edge wins over a clear.
      if (bad_move) begin
        err <= 1'b1;
      end else if (clr_err) begin
        err <= 1'b0;
      end
    end
  end

  assign state_dbg = (state == TRACK);

endmodule

// File: tb/tb_quad_step_decoder.sv
// Bench for quad_step_decoder: directed scenarios plus randomized encoder
// traffic, checked against a sliding-window reference model.
module tb_quad_step_decoder;

  localparam int CW = 3;
  localparam int FL = 3;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enc_a = 1'b0;
  logic          enc_b = 1'b0;
  logic          load = 1'b0;
  logic [CW-1:0] counter_in = '0;
  logic          clr_err = 1'b0;
  logic          step;
  logic          up_down;
  logic [CW-1:0] counter_out;
  logic          err;
  logic          state_dbg;

  always #5 clk = ~clk;

  quad_step_decoder #(.CNT_WIDTH(CW), .FILTER_LEN(FL)) dut (
    .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b),
    .load(load), .counter_in(counter_in), .clr_err(clr_err),
    .step(step), .up_down(up_down), .counter_out(counter_out),
    .err(err), .state_dbg(state_dbg)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Expected step responses: {direction, position}.
  logic [CW:0]   exp_q[$];
  logic [1:0]    m_s1, m_s2, m_filt;
  logic [1:0]    m_win[$];
  bit            m_primed, m_err, m_dir;
  logic [CW-1:0] m_cnt;

  function automatic logic [1:0] up_next(input logic [1:0] p);
    case (p)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  task automatic model_reset();
    m_s1 = 2'b00; m_s2 = 2'b00; m_filt = 2'b00;
    m_win.delete();
    m_primed = 0; m_err = 0; m_dir = 0; m_cnt = '0;
    exp_q.delete();
  endtask

  task automatic model_edge();
    logic [1:0] samp;
    bit acc, mv_up, mv_dn, mv_bad;
    samp = m_s2;
    m_s2 = m_s1;
    m_s1 = {enc_a, enc_b};
    m_win.push_back(samp);
    if (m_win.size() > FL) void'(m_win.pop_front());
    acc = (m_win.size() == FL) && (samp != m_filt);
    foreach (m_win[i]) if (m_win[i] != samp) acc = 0;
    mv_up = 0; mv_dn = 0; mv_bad = 0;
    if (acc) begin
      if (!m_primed) m_primed = 1;
      else if (samp == up_next(m_filt)) mv_up = 1;
      else if (m_filt == up_next(samp)) mv_dn = 1;
      else mv_bad = 1;
      m_filt = samp;
    end
    if (mv_up) begin m_dir = 1; m_cnt = m_cnt + 1'b1; end
    if (mv_dn) begin m_dir = 0; m_cnt = m_cnt - 1'b1; end
    if (load) m_cnt = counter_in;
    if (mv_up || mv_dn) exp_q.push_back({m_dir, m_cnt});
    if (mv_bad) m_err = 1;
    else if (clr_err) m_err = 0;
  endtask

  initial model_reset();
  always @(posedge reset) model_reset();
  always @(posedge clk) begin
    if (reset) model_reset();
    else model_edge();
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [CW:0] e;
    if (step) begin
      check("step_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("step_payload", 32'({up_down, counter_out}), 32'(e));
      end
    end else begin
      check("step_missing", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    check("counter_out", 32'(counter_out), 32'(m_cnt));
    check("err", 32'(err), 32'(m_err));
    check("up_down", 32'(up_down), 32'(m_dir));
    check("primed", 32'(state_dbg), 32'(m_primed));
  end

  // ---------------- driver tasks ----------------
  // Hold a pair for n cycles; optionally pulse load on cycle load_at.
  task automatic hold(input logic [1:0] ab, input int n, input int load_at = -1,
                      input logic [CW-1:0] cin = '0);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      {enc_a, enc_b} = ab;
      load = (i == load_at);
      counter_in = cin;
      clr_err = 1'b0;
    end
  endtask

  task automatic pulse_load(input logic [CW-1:0] cin, input logic [1:0] ab);
    @(negedge clk);
    {enc_a, enc_b} = ab; load = 1'b1; counter_in = cin; clr_err = 1'b0;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic pulse_clr(input logic [1:0] ab);
    @(negedge clk);
    {enc_a, enc_b} = ab; load = 1'b0; clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0] cur, nxt;
    int r;

    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Priming on 11: no step, no err, count stays 0.
    hold(2'b11, 10);
    check("prime_count", 32'(counter_out), 32'd0);
    check("prime_err", 32'(err), 32'd0);
    check("prime_state", 32'(state_dbg), 32'd1);

    // Five up moves from 11: 01, 00, 10, 11, 01.
    hold(2'b01, 6); hold(2'b00, 6); hold(2'b10, 6); hold(2'b11, 6); hold(2'b01, 6);
    check("up_count", 32'(counter_out), 32'd5);
    check("up_dir", 32'(up_down), 32'd1);

    // Load 3 then four down moves from 01: 11, 10, 00, 01 -> 2,1,0,7.
    pulse_load(3'd3, 2'b01);
    check("load_value", 32'(counter_out), 32'd3);
    hold(2'b11, 6); hold(2'b10, 6); hold(2'b00, 6); hold(2'b01, 6);
    check("down_wrap", 32'(counter_out), 32'd7);
    check("down_dir", 32'(up_down), 32'd0);

    // Up move 01 -> 00 with load landing on the step edge.
    hold(2'b00, 8, 4, 3'd5);
    check("load_step_count", 32'(counter_out), 32'd5);
    check("load_step_dir", 32'(up_down), 32'd1);

    // Two-cycle glitch on A: ignored.
    hold(2'b10, 2); hold(2'b00, 8);
    check("glitch_count", 32'(counter_out), 32'd5);
    check("glitch_err", 32'(err), 32'd0);

    // Double-bit move 00 -> 11: err, no count change.
    hold(2'b11, 6);
    check("illegal_err", 32'(err), 32'd1);
    check("illegal_count", 32'(counter_out), 32'd5);
    pulse_clr(2'b11);
    check("clr_err", 32'(err), 32'd0);

    // Randomized traffic with glitches, illegal moves, loads and clears.
    cur = 2'b11;
    for (int seg = 0; seg < 300; seg++) begin
      r = $urandom_range(0, 9);
      if (r < 4) nxt = up_next(cur);
      else if (r < 8) begin
        nxt = 2'b00;
        for (int k = 0; k < 4; k++) if (up_next(2'(k)) == cur) nxt = 2'(k);
      end else nxt = 2'($urandom_range(0, 3));
      cur = nxt;
      for (int c = $urandom_range(1, 7); c > 0; c--) begin
        @(negedge clk);
        {enc_a, enc_b} = cur;
        load = ($urandom_range(0, 19) == 0);
        counter_in = CW'($urandom_range(0, 7));
        clr_err = ($urandom_range(0, 9) == 0);
      end
    end
    hold(cur, 8);

    // Reset mid-operation at count 6, asynchronous to clk.
    pulse_load(3'd6, cur);
    hold(cur, 2);
    check("pre_reset_count", 32'(counter_out), 32'd6);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_rst_count", 32'(counter_out), 32'd0);
    check("async_rst_step", 32'(step), 32'd0);
    check("async_rst_dir", 32'(up_down), 32'd0);
    check("async_rst_err", 32'(err), 32'd0);
    check("async_rst_state", 32'(state_dbg), 32'd0);
    enc_a = 1'b0; enc_b = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    hold(2'b01, 10);
    check("reprime_state", 32'(state_dbg), 32'd1);
    check("reprime_count", 32'(counter_out), 32'd0);
    check("reprime_err", 32'(err), 32'd0);

    hold(2'b01, 3);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
